// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, sequencer state encoding and the buffered request payload.
package alu_pkg;
  localparam int ALU_REGSEL_W = 3;
  localparam logic [3:0] ALU_ADD = 4'h0, ALU_ADC = 4'h1, ALU_SUB = 4'h2, ALU_SBC = 4'h3;
  localparam logic [3:0] ALU_AND = 4'h4, ALU_OR = 4'h5, ALU_XOR = 4'h6, ALU_CMP = 4'h7;
  typedef logic [2:0] seq_state_t;
  localparam seq_state_t S_IDLE = 3'd0, S_SEL = 3'd1, S_LATCH = 3'd2, S_WRC = 3'd3;
  localparam seq_state_t S_CMTC = 3'd4, S_WRF = 3'd5, S_CMTF = 3'd6, S_DONE = 3'd7;
  typedef struct packed {
    logic [3:0]              op;
    logic [ALU_REGSEL_W-1:0] sel_a;
    logic [ALU_REGSEL_W-1:0] sel_b;
    logic [ALU_REGSEL_W-1:0] sel_c;
    logic                    setf;
  } alu_req_t;
endpackage

// File: rtl/constants_pkg.sv
// constants_pkg: shared bus width and ALU bus command encoding.
package constants_pkg;
  localparam int WORDSIZE = 16;
  typedef enum logic [1:0] {COM_NOP, COM_LATCHOP, COM_WRITEC, COM_WRITEF} command_t;
endpackage

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: synchronous request FIFO; pointers carry one wrap bit to split full from empty.
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     i_Clk,
  input  logic     i_Reset_n,
  input  logic     push,
  input  logic     pop,
  input  alu_req_t wdata,
  output alu_req_t rdata,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  alu_req_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge i_Clk or negedge i_Reset_n)
    if (!i_Reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge i_Clk)
    if (push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues LATCHOP/WRITEC/WRITEF bus commands for one buffered ALU instruction at a time.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WORDSIZE = constants_pkg::WORDSIZE,
  parameter int REGSEL_W = ALU_REGSEL_W,
  parameter int Q_DEPTH  = 2
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [3:0]              i_req_op,
  input  logic [REGSEL_W-1:0]     i_req_sel_a,
  input  logic [REGSEL_W-1:0]     i_req_sel_b,
  input  logic [REGSEL_W-1:0]     i_req_sel_c,
  input  logic                    i_req_setf,
  output logic [REGSEL_W-1:0]     o_sel_a,
  output logic [REGSEL_W-1:0]     o_sel_b,
  output logic [REGSEL_W-1:0]     o_sel_c,
  output constants_pkg::command_t o_bus_command,
  output logic                    o_bus_valid,
  output logic [WORDSIZE-1:0]     o_bus_data,
  output logic                    o_rf_we,
  output logic                    o_done,
  output logic                    o_busy,
  output logic [15:0]             o_done_count
);
  seq_state_t state, nxt;
  alu_req_t head, cur, wreq;
  logic full, empty, push, pop;
  logic [15:0] done_cnt;
  assign push = i_req_valid && !full;
  assign pop = (state == S_IDLE || state == S_DONE) && !empty;
  assign o_req_ready = !full;
  assign o_busy = state != S_IDLE || !empty;
  assign o_done_count = done_cnt;
  assign wreq = '{op: i_req_op, sel_a: ALU_REGSEL_W'(i_req_sel_a), sel_b: ALU_REGSEL_W'(i_req_sel_b),
                  sel_c: ALU_REGSEL_W'(i_req_sel_c), setf: i_req_setf};
  alu_req_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .push(push), .pop(pop),
    .wdata(wreq), .rdata(head), .full(full), .empty(empty)
  );
  always_comb begin
    nxt = S_IDLE;
    unique case (state)
      S_IDLE:  nxt = empty ? S_IDLE : S_SEL;
      S_SEL:   nxt = S_LATCH;
      S_LATCH: nxt = cur.op != ALU_CMP ? S_WRC : cur.setf ? S_WRF : S_DONE;
      S_WRC:   nxt = S_CMTC;
      S_CMTC:  nxt = cur.setf ? S_WRF : S_DONE;
      S_WRF:   nxt = S_CMTF;
      S_CMTF:  nxt = S_DONE;
      S_DONE:  nxt = empty ? S_IDLE : S_SEL;
      default: nxt = S_IDLE;
    endcase
  end
  // Outputs are registered decodes of the current state, so they trail the state by one cycle.
  always_ff @(posedge i_Clk or negedge i_Reset_n)
    if (!i_Reset_n) begin
      state         <= S_IDLE;
      cur           <= '0;
      o_bus_command <= constants_pkg::COM_NOP;
      o_bus_valid   <= 1'b0;
      o_bus_data    <= '0;
      o_rf_we       <= 1'b0;
      o_done        <= 1'b0;
      done_cnt      <= '0;
      o_sel_a       <= '0;
      o_sel_b       <= '0;
      o_sel_c       <= '0;
    end else begin
      state         <= nxt;
      if (pop) cur <= head;
      o_bus_command <= state == S_LATCH ? constants_pkg::COM_LATCHOP :
                       state == S_WRC   ? constants_pkg::COM_WRITEC  :
                       state == S_WRF   ? constants_pkg::COM_WRITEF  : constants_pkg::COM_NOP;
      o_bus_valid   <= state == S_LATCH;
      o_bus_data    <= state == S_LATCH ? WORDSIZE'(cur.op) : '0;
      o_rf_we       <= state == S_CMTC || state == S_CMTF;
      o_done        <= state == S_DONE;
      if (state == S_DONE) done_cnt <= done_cnt + 1'b1;
      o_sel_a       <= state == S_IDLE ? '0 : REGSEL_W'(cur.sel_a);
      o_sel_b       <= state == S_IDLE ? '0 : REGSEL_W'(cur.sel_b);
      o_sel_c       <= state == S_IDLE ? '0 : REGSEL_W'(cur.sel_c);
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Bus initiator that drives the ALU's command protocol for one ALU instruction at a time.
- Accepts an instruction (op, A/B/C register selects, flag-update enable) over a valid/ready handshake.
- Drives register-file selects and the bus command sequence: latch op, write C, write F.
- Sits between the instruction decode stage and the shared bus / register file; it is the only agent issuing ALU commands.

Parameters:
- WORDSIZE, 16, bus data width.
- REGSEL_W, 3, width of each register-file select.
- Q_DEPTH, 2, request buffer entries; must be a power of two and at least 2.

Ports:
- i_Clk  in  1  clock
- i_Reset_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  instruction request valid
- o_req_ready  out  1  request buffer not full
- i_req_op  in  4  ALU opcode
- i_req_sel_a  in  REGSEL_W  A register select
- i_req_sel_b  in  REGSEL_W  B register select
- i_req_sel_c  in  REGSEL_W  destination register select
- i_req_setf  in  1  commit flags to F when 1
- o_sel_a / o_sel_b / o_sel_c  out  REGSEL_W  register-file selects
- o_bus_command  out  command_t  bus command
- o_bus_valid  out  1  qualifies o_bus_data
- o_bus_data  out  WORDSIZE  bus data; carries {zero-extended op} in LATCHOP
- o_rf_we  out  1  register-file write strobe for the ALU's registered write data/select
- o_done  out  1  one-cycle pulse when an instruction completes
- o_busy  out  1  FSM not in IDLE, or buffer not empty
- o_done_count  out  16  completed-instruction counter

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE and the buffer empties.
  - o_bus_command=COM_NOP; o_bus_valid=0; o_bus_data=0; selects=0.
  - o_rf_we=0; o_done=0; o_done_count=0; o_req_ready=1.
  - Reset asserted mid-instruction abandons the instruction; no further commands are issued.
- Request buffer:
  - Synchronous FIFO of Q_DEPTH entries.
  - Push on i_req_valid & o_req_ready; o_req_ready = !full.
  - Pop on entering SEL from IDLE or from DONE.
  - Simultaneous push and pop when full is not possible, because ready is low when full.
- FSM states, one cycle each unless stated:
  - IDLE: all outputs inactive; if buffer not empty -> SEL.
  - SEL: drive o_sel_a/b/c from the head entry and hold them until DONE exits; command NOP -> LATCH.
  - LATCH: command=COM_LATCHOP, o_bus_valid=1, o_bus_data={WORDSIZE-4 zeros, op} -> WRC; if op==ALU_CMP -> WRF if setf, else DONE.
  - WRC: command=COM_WRITEC -> CMTC.
  - CMTC: command=NOP, o_rf_we=1 (ALU output registered in WRC is now stable) -> WRF if setf, else DONE.
  - WRF: command=COM_WRITEF -> CMTF.
  - CMTF: command=NOP, o_rf_we=1 -> DONE.
  - DONE: o_done=1; o_done_count increments, wrapping 0xFFFF -> 0x0000; if buffer not empty -> SEL, else IDLE.
- Latency, acceptance to o_done with an empty buffer and idle FSM:
  - ADD with setf=1: 8 cycles.
  - ADD with setf=0: 6 cycles.
  - CMP with setf=1: 6 cycles.
  - CMP with setf=0: 4 cycles.
- Back-to-back instructions: DONE goes directly to SEL; there is never more than one ALU command in flight.
- o_bus_valid is 1 only in LATCH. All bus outputs are registered. o_bus_data=0 whenever valid=0.
- Selects are held stable from SEL through DONE, because the ALU result is combinational on the selected registers.

Decomposition:
- alu_pkg (shared): seq_state_t enum, and the ALU_CMP opcode already defined there.
- constants_pkg (shared): command_t and COM_NOP/COM_LATCHOP/COM_WRITEC/COM_WRITEF, already defined there; WORDSIZE.
- One natural sub-module: alu_req_fifo, a parameterised sync FIFO with push/pop/full/empty and a request struct payload. The request struct alu_req_t goes in alu_pkg.

Test Plan:
- Reset mid-op: assert i_Reset_n=0 during WRC -> outputs go to reset values asynchronously; after release, IDLE with done_count=0 and no COM_WRITEC seen.
- ADD, setf=1, sel A=1 B=2 C=3, regs 0x0005/0x0003 -> exact sequence LATCHOP(0x0000+ALU_ADD), WRITEC, rf_we, WRITEF, rf_we, done; C=0x0008; F carry=0, zero=0; 8 cycles.
- CMP, setf=0, A=B=0x1234 -> LATCHOP then done, with no WRITEC/WRITEF and no rf_we; 4 cycles.
- Flood: hold req_valid for 4 requests back-to-back -> ready deasserts after 2 buffered; all 4 complete in order; done_count=4; no gap cycle between DONE and SEL.
- ADC chain: ADD 0xFFFF+0x0001 (setf) then ADC 0x0000+0x0000 -> first C=0x0000 with carry=1, zero=1; second C=0x0001.
- Counter wrap: preload via 65536 CMP/setf=0 ops (or force) -> done_count wraps to 0x0000, with no other side effects.
